// File: rtl/shared_main_mem_pkg.sv
// Shared definitions for the dual-core cache system: bus encodings, widths and
// the main-memory fetch FSM states.
package shared_main_mem_pkg;

    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] BUS_INVALIDATE = 2'b00;
    localparam logic [1:0] BUS_WRITE_MISS = 2'b01;
    localparam logic [1:0] BUS_READ_MISS  = 2'b10;

    // Write-back holding registers, index order is also drain priority.
    localparam int unsigned NUM_WB = 4;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StHold,
        StDeliver
    } fetch_state_e;

endpackage

// File: rtl/shared_main_mem_fetch_fsm.sv
// Per-core read-miss fetch sequencer: fixed latency, then waits out queued
// write-backs so the delivered word is never stale.
module mem_fetch_fsm #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              abort,
    input  logic              wb_pending,
    output logic              busy,
    output logic              deliver,
    output logic [ADDR_W-1:0] fetch_addr
);
    import shared_main_mem_pkg::*;

    fetch_state_e      state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    addr_d = rd_addr;
                    if (RD_LAT <= 1) begin
                        state_d = wb_pending ? StHold : StDeliver;
                    end else begin
                        cnt_d   = 3'(RD_LAT - 1);
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                cnt_d = cnt_q - 3'd1;
                if (abort) begin
                    state_d = StIdle;
                end else if (cnt_d == 3'd0) begin
                    state_d = wb_pending ? StHold : StDeliver;
                end
            end
            StHold: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!wb_pending) begin
                    state_d = StDeliver;
                end
            end
            StDeliver: state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign deliver    = (state_q == StDeliver);
    assign fetch_addr = addr_q;

endmodule

// File: rtl/shared_main_mem.sv
// Shared main memory: four write-back holding registers drained by a fixed
// priority arbiter into a 1W/2R array, plus one fetch sequencer per core.
module shared_main_mem #(
    parameter int unsigned ADDR_W = shared_main_mem_pkg::ADDR_W,
    parameter int unsigned DATA_W = shared_main_mem_pkg::DATA_W,
    parameter int unsigned RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wb_0,
    input  logic [ADDR_W-1:0] cpu_wb_addr_0,
    input  logic [DATA_W-1:0] cpu_wb_data_0,
    input  logic              cpu_wb_1,
    input  logic [ADDR_W-1:0] cpu_wb_addr_1,
    input  logic [DATA_W-1:0] cpu_wb_data_1,
    input  logic              bus_wb_0,
    input  logic [ADDR_W-1:0] bus_wb_addr_0,
    input  logic [DATA_W-1:0] bus_wb_data_0,
    input  logic              bus_wb_1,
    input  logic [ADDR_W-1:0] bus_wb_addr_1,
    input  logic [DATA_W-1:0] bus_wb_data_1,
    input  logic              rd_req_0,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic              rd_req_1,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic              abort_0,
    input  logic              abort_1,
    output logic [DATA_W-1:0] mem_data_delivery_0,
    output logic              mem_data_valid_0,
    output logic [DATA_W-1:0] mem_data_delivery_1,
    output logic              mem_data_valid_1,
    output logic              rd_busy_0,
    output logic              rd_busy_1,
    output logic              wb_overflow
);
    import shared_main_mem_pkg::*;

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [NUM_WB-1:0] wb_pulse;
    logic [ADDR_W-1:0] wb_addr [NUM_WB];
    logic [DATA_W-1:0] wb_data [NUM_WB];

    logic [NUM_WB-1:0] hold_valid_q, hold_valid_d;
    logic [ADDR_W-1:0] hold_addr_q [NUM_WB];
    logic [ADDR_W-1:0] hold_addr_d [NUM_WB];
    logic [DATA_W-1:0] hold_data_q [NUM_WB];
    logic [DATA_W-1:0] hold_data_d [NUM_WB];
    logic              overflow_q, overflow_d;

    logic [NUM_WB-1:0] grant;
    logic              drain_valid;
    logic [ADDR_W-1:0] drain_addr;
    logic [DATA_W-1:0] drain_data;
    logic              wb_pending;

    logic [DATA_W-1:0] mem [DEPTH];

    assign wb_pulse   = {cpu_wb_1, bus_wb_1, cpu_wb_0, bus_wb_0};
    assign wb_addr[0] = bus_wb_addr_0;
    assign wb_addr[1] = cpu_wb_addr_0;
    assign wb_addr[2] = bus_wb_addr_1;
    assign wb_addr[3] = cpu_wb_addr_1;
    assign wb_data[0] = bus_wb_data_0;
    assign wb_data[1] = cpu_wb_data_0;
    assign wb_data[2] = bus_wb_data_1;
    assign wb_data[3] = cpu_wb_data_1;

    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (hold_valid_q[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        drain_addr = '0;
        drain_data = '0;
        for (int i = 0; i < NUM_WB; i++) begin
            if (grant[i]) begin
                drain_addr = hold_addr_q[i];
                drain_data = hold_data_q[i];
            end
        end
    end

    assign drain_valid = |grant;

    // A register that drains this cycle frees its slot for a same-cycle pulse.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_addr_d  = hold_addr_q;
        hold_data_d  = hold_data_q;
        overflow_d   = overflow_q;
        for (int i = 0; i < NUM_WB; i++) begin
            if (wb_pulse[i]) begin
                if (hold_valid_q[i] && !grant[i]) begin
                    overflow_d = 1'b1;
                end else begin
                    hold_valid_d[i] = 1'b1;
                    hold_addr_d[i]  = wb_addr[i];
                    hold_data_d[i]  = wb_data[i];
                end
            end else if (grant[i]) begin
                hold_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid_q <= '0;
            overflow_q   <= 1'b0;
            for (int i = 0; i < NUM_WB; i++) begin
                hold_addr_q[i] <= '0;
                hold_data_q[i] <= '0;
            end
        end else begin
            hold_valid_q <= hold_valid_d;
            overflow_q   <= overflow_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (drain_valid) begin
            mem[drain_addr] <= drain_data;
        end
    end

    // Fetches look at next-cycle occupancy so a write-back draining now does not stall them.
    assign wb_pending = |hold_valid_d;

    logic [1:0]        rd_req_v, abort_v, deliver, busy;
    logic [ADDR_W-1:0] rd_addr_v  [2];
    logic [ADDR_W-1:0] fetch_addr [2];
    logic [DATA_W-1:0] data_out   [2];

    assign rd_req_v     = {rd_req_1, rd_req_0};
    assign abort_v      = {abort_1, abort_0};
    assign rd_addr_v[0] = rd_addr_0;
    assign rd_addr_v[1] = rd_addr_1;

    for (genvar c = 0; c < 2; c++) begin : g_core
        logic [DATA_W-1:0] rd_word;
        logic [DATA_W-1:0] delivery_q;

        mem_fetch_fsm #(
            .ADDR_W(ADDR_W),
            .RD_LAT(RD_LAT)
        ) u_fsm (
            .clk        (clk),
            .reset      (reset),
            .rd_req     (rd_req_v[c]),
            .rd_addr    (rd_addr_v[c]),
            .abort      (abort_v[c]),
            .wb_pending (wb_pending),
            .busy       (busy[c]),
            .deliver    (deliver[c]),
            .fetch_addr (fetch_addr[c])
        );

        assign rd_word = (drain_valid && drain_addr == fetch_addr[c]) ? drain_data
                                                                       : mem[fetch_addr[c]];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                delivery_q <= '0;
            end else if (deliver[c]) begin
                delivery_q <= rd_word;
            end
        end

        assign data_out[c] = deliver[c] ? rd_word : delivery_q;
    end

    assign mem_data_delivery_0 = data_out[0];
    assign mem_data_delivery_1 = data_out[1];
    assign mem_data_valid_0    = deliver[0];
    assign mem_data_valid_1    = deliver[1];
    assign rd_busy_0           = busy[0];
    assign rd_busy_1           = busy[1];
    assign wb_overflow         = overflow_q;

endmodule

// File: tb/tb_shared_main_mem.sv
// Directed bench for shared_main_mem: per-cycle stimulus/expectation table plus
// a bounded-latency fetch sequence.
module tb_shared_main_mem;

    logic        clk;
    logic        reset;
    logic        cpu_wb_0, cpu_wb_1, bus_wb_0, bus_wb_1;
    logic [8:0]  cpu_wb_addr_0, cpu_wb_addr_1, bus_wb_addr_0, bus_wb_addr_1;
    logic [31:0] cpu_wb_data_0, cpu_wb_data_1, bus_wb_data_0, bus_wb_data_1;
    logic        rd_req_0, rd_req_1, abort_0, abort_1;
    logic [8:0]  rd_addr_0, rd_addr_1;
    logic [31:0] mem_data_delivery_0, mem_data_delivery_1;
    logic        mem_data_valid_0, mem_data_valid_1;
    logic        rd_busy_0, rd_busy_1, wb_overflow;

    shared_main_mem #(
        .ADDR_W(9),
        .DATA_W(32),
        .RD_LAT(2)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_wb_0            (cpu_wb_0),
        .cpu_wb_addr_0       (cpu_wb_addr_0),
        .cpu_wb_data_0       (cpu_wb_data_0),
        .cpu_wb_1            (cpu_wb_1),
        .cpu_wb_addr_1       (cpu_wb_addr_1),
        .cpu_wb_data_1       (cpu_wb_data_1),
        .bus_wb_0            (bus_wb_0),
        .bus_wb_addr_0       (bus_wb_addr_0),
        .bus_wb_data_0       (bus_wb_data_0),
        .bus_wb_1            (bus_wb_1),
        .bus_wb_addr_1       (bus_wb_addr_1),
        .bus_wb_data_1       (bus_wb_data_1),
        .rd_req_0            (rd_req_0),
        .rd_addr_0           (rd_addr_0),
        .rd_req_1            (rd_req_1),
        .rd_addr_1           (rd_addr_1),
        .abort_0             (abort_0),
        .abort_1             (abort_1),
        .mem_data_delivery_0 (mem_data_delivery_0),
        .mem_data_valid_0    (mem_data_valid_0),
        .mem_data_delivery_1 (mem_data_delivery_1),
        .mem_data_valid_1    (mem_data_valid_1),
        .rd_busy_0           (rd_busy_0),
        .rd_busy_1           (rd_busy_1),
        .wb_overflow         (wb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One row per clock cycle: inputs driven during the cycle, outputs expected in it.
    // wb bit order: bus0, cpu0, bus1, cpu1. With spread set, source i uses addr+i, data+i.
    typedef struct packed {
        logic        rst;
        logic [3:0]  wb;
        logic        spread;
        logic [8:0]  wb_addr;
        logic [31:0] wb_data;
        logic [1:0]  req;
        logic [8:0]  ra0;
        logic [8:0]  ra1;
        logic [1:0]  abort;
        logic [1:0]  ev;
        logic [1:0]  eb;
        logic        eo;
        logic [31:0] ed0;
        logic [31:0] ed1;
    } vec_t;

    vec_t vecs [$];
    int   n_vec;
    int   n_miss;

    function automatic void add(input int unsigned rst, input int unsigned wb,
                                input int unsigned spread, input int unsigned wa,
                                input int unsigned wd, input int unsigned req,
                                input int unsigned ra0, input int unsigned ra1,
                                input int unsigned ab, input int unsigned ev,
                                input int unsigned eb, input int unsigned eo,
                                input int unsigned ed0, input int unsigned ed1);
        vec_t v;
        v.rst     = 1'(rst);
        v.wb      = 4'(wb);
        v.spread  = 1'(spread);
        v.wb_addr = 9'(wa);
        v.wb_data = wd;
        v.req     = 2'(req);
        v.ra0     = 9'(ra0);
        v.ra1     = 9'(ra1);
        v.abort   = 2'(ab);
        v.ev      = 2'(ev);
        v.eb      = 2'(eb);
        v.eo      = 1'(eo);
        v.ed0     = ed0;
        v.ed1     = ed1;
        vecs.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        logic [8:0]  ao;
        logic [31:0] dof;
        reset         = v.rst;
        bus_wb_0      = v.wb[0];
        bus_wb_addr_0 = v.wb_addr;
        bus_wb_data_0 = v.wb_data;
        ao  = v.spread ? 9'd1 : 9'd0;
        dof = v.spread ? 32'd1 : 32'd0;
        cpu_wb_0      = v.wb[1];
        cpu_wb_addr_0 = v.wb_addr + ao;
        cpu_wb_data_0 = v.wb_data + dof;
        ao  = v.spread ? 9'd2 : 9'd0;
        dof = v.spread ? 32'd2 : 32'd0;
        bus_wb_1      = v.wb[2];
        bus_wb_addr_1 = v.wb_addr + ao;
        bus_wb_data_1 = v.wb_data + dof;
        ao  = v.spread ? 9'd3 : 9'd0;
        dof = v.spread ? 32'd3 : 32'd0;
        cpu_wb_1      = v.wb[3];
        cpu_wb_addr_1 = v.wb_addr + ao;
        cpu_wb_data_1 = v.wb_data + dof;
        rd_req_0      = v.req[0];
        rd_addr_0     = v.ra0;
        rd_req_1      = v.req[1];
        rd_addr_1     = v.ra1;
        abort_0       = v.abort[0];
        abort_1       = v.abort[1];
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        int lat0, lat1;
        logic [31:0] got0, got1;
        n_vec  = 0;
        n_miss = 0;
        apply('0);
        reset = 1'b1;

        //  rst wb     sp wb_addr wb_data      req  ra0    ra1    ab   ev   eb  eo ed0 ed1
        add(1, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h0, 'h0);
        // Preload 014 and fetch it on core 0.
        add(0, 'b0001, 0, 'h014, 'hDEADBEEF, 'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h0, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h0, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b01, 'h014, 'h000, 'b00, 'b00, 'b00, 0,
            'h0, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b01, 0,
            'h0, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b01, 'b01, 0,
            'hDEADBEEF, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hDEADBEEF, 'h0);
        // cpu_wb_1 and a core-0 fetch of the same word in one cycle.
        add(0, 'b1000, 0, 'h0A0, 'h12345678, 'b01, 'h0A0, 'h000, 'b00, 'b00, 'b00, 0,
            'hDEADBEEF, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b01, 0,
            'hDEADBEEF, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b01, 'b01, 0,
            'h12345678, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h12345678, 'h0);
        // Four simultaneous write-backs to 100..103, then read them back.
        add(0, 'b1111, 1, 'h100, 'hA0000000, 'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h12345678, 'h0);
        for (int k = 0; k < 3; k++)
            add(0, 'b0000, 0, 'h000, 'h0,    'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
                'h12345678, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b11, 'h103, 'h100, 'b00, 'b00, 'b00, 0,
            'h12345678, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b11, 0,
            'h12345678, 'h0);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b11, 'b11, 0,
            'hA0000003, 'hA0000000);
        add(0, 'b0000, 0, 'h000, 'h0,        'b11, 'h101, 'h102, 'b00, 'b00, 'b00, 0,
            'hA0000003, 'hA0000000);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b11, 0,
            'hA0000003, 'hA0000000);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b11, 'b11, 0,
            'hA0000001, 'hA0000002);
        // Abort in WAIT; then a request with abort held in IDLE still proceeds.
        add(0, 'b0000, 0, 'h000, 'h0,        'b10, 'h000, 'h014, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hA0000002);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b10, 'b00, 'b10, 0,
            'hA0000001, 'hA0000002);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hA0000002);
        add(0, 'b0000, 0, 'h000, 'h0,        'b10, 'h000, 'h014, 'b10, 'b00, 'b00, 0,
            'hA0000001, 'hA0000002);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b10, 0,
            'hA0000001, 'hA0000002);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b10, 'b10, 0,
            'hA0000001, 'hDEADBEEF);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hDEADBEEF);
        // HOLD: cpu_wb_1 (033=CAFEF00D) starved by bus_wb_0 traffic while core 1 fetches 033.
        add(0, 'b1011, 1, 'h030, 'hCAFEF00A, 'b10, 'h000, 'h033, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hDEADBEEF);
        for (int k = 0; k < 3; k++)
            add(0, 'b0001, 0, 'h040 + k, 'h0, 'b00, 'h000, 'h000, 'b00, 'b00, 'b10, 0,
                'hA0000001, 'hDEADBEEF);
        for (int k = 0; k < 3; k++)
            add(0, 'b0000, 0, 'h000, 'h0,    'b00, 'h000, 'h000, 'b00, 'b00, 'b10, 0,
                'hA0000001, 'hDEADBEEF);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b10, 'b10, 0,
            'hA0000001, 'hCAFEF00D);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hCAFEF00D);
        // Overflow: bus_wb_1 pulsed twice while bus_wb_0 holds the arbiter.
        add(0, 'b0111, 1, 'h050, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hCAFEF00D);
        add(0, 'b0101, 1, 'h060, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'hA0000001, 'hCAFEF00D);
        add(0, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 1,
            'hA0000001, 'hCAFEF00D);
        // Reset in the middle of a fetch clears everything, no late strobe.
        add(0, 'b0000, 0, 'h000, 'h0,        'b01, 'h100, 'h000, 'b00, 'b00, 'b00, 1,
            'hA0000001, 'hCAFEF00D);
        add(1, 'b0000, 0, 'h000, 'h0,        'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
            'h0, 'h0);
        for (int k = 0; k < 3; k++)
            add(0, 'b0000, 0, 'h000, 'h0,    'b00, 'h000, 'h000, 'b00, 'b00, 'b00, 0,
                'h0, 'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            #1;
            check("valid0",   i, 32'(mem_data_valid_0),  32'(vecs[i].ev[0]));
            check("valid1",   i, 32'(mem_data_valid_1),  32'(vecs[i].ev[1]));
            check("busy0",    i, 32'(rd_busy_0),         32'(vecs[i].eb[0]));
            check("busy1",    i, 32'(rd_busy_1),         32'(vecs[i].eb[1]));
            check("overflow", i, 32'(wb_overflow),       32'(vecs[i].eo));
            check("data0",    i, mem_data_delivery_0,    vecs[i].ed0);
            check("data1",    i, mem_data_delivery_1,    vecs[i].ed1);
        end

        // Array survives reset (0A0), and a same-cycle bus_wb_1/fetch pair sees new data.
        @(posedge clk);
        #1;
        rd_req_1      = 1'b1;
        rd_addr_1     = 9'h0A0;
        rd_req_0      = 1'b1;
        rd_addr_0     = 9'h1FF;
        bus_wb_1      = 1'b1;
        bus_wb_addr_1 = 9'h1FF;
        bus_wb_data_1 = 32'h5A5A5A5A;
        lat0 = -1;
        lat1 = -1;
        got0 = '0;
        got1 = '0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            rd_req_0 = 1'b0;
            rd_req_1 = 1'b0;
            bus_wb_1 = 1'b0;
            #1;
            if (mem_data_valid_0 && lat0 < 0) begin
                lat0 = k;
                got0 = mem_data_delivery_0;
            end
            if (mem_data_valid_1 && lat1 < 0) begin
                lat1 = k;
                got1 = mem_data_delivery_1;
            end
        end
        check("seq_lat0",  -1, 32'(lat0), 32'd2);
        check("seq_data0", -1, got0,      32'h5A5A5A5A);
        check("seq_lat1",  -1, 32'(lat1), 32'd2);
        check("seq_data1", -1, got1,      32'h12345678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/shared_main_mem.md
# shared_main_mem

Shared main-memory responder at the bottom of the dual-core coherent system: the far end of each L1 cache's memory-side ports. It accepts write-back pulses (CPU-side eviction and bus-side flush) from both L1 caches and serves read-miss fetches per core with a fixed latency. A fetch is cancelled when the other cache announces it is supplying the line over the snoop bus. Storage is 512 words × 32 bits, word-addressed by the caches' 9-bit addresses.

## Interface
Parameters:
- `ADDR_W`, 9: word address width.
- `DATA_W`, 32: word width.
- `RD_LAT`, 2: minimum cycles from fetch request to data delivery; legal range 1..7.

Ports (suffix `_c` means one instance for core 0 and one for core 1, e.g. `rd_req_0` / `rd_req_1`):
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cpu_wb_c` in 1: CPU-side write-back pulse, one cycle per word.
- `cpu_wb_addr_c` in ADDR_W: address for `cpu_wb_c`.
- `cpu_wb_data_c` in DATA_W: data for `cpu_wb_c`.
- `bus_wb_c` in 1: bus-side (snoop flush) write-back pulse.
- `bus_wb_addr_c` in ADDR_W: address for `bus_wb_c`.
- `bus_wb_data_c` in DATA_W: data for `bus_wb_c`.
- `rd_req_c` in 1: fetch pulse; driven from the cache's `ask_mem_address` change on a miss.
- `rd_addr_c` in ADDR_W: fetch address.
- `abort_c` in 1: other core's `bus_reply_abort_mem_access`; cancels core c's pending fetch.
- `mem_data_delivery_c` out DATA_W: fetched word.
- `mem_data_valid_c` out 1: one-cycle strobe; `mem_data_delivery_c` is valid.
- `rd_busy_c` out 1: fetch pending for core c.
- `wb_overflow` out 1: sticky; a write-back pulse was dropped.

## Operation
- Four write-back holding registers (addr, data, valid), one per source: `bus_wb_0`, `cpu_wb_0`, `bus_wb_1`, `cpu_wb_1`.
  - A pulse loads its holding register.
  - If the register is already valid and not draining this cycle, the pulse is dropped and `wb_overflow` is set. It clears only on reset.
- Drain arbiter commits one holding register per cycle to the array.
  - Fixed priority: `bus_wb_0` > `cpu_wb_0` > `bus_wb_1` > `cpu_wb_1`.
  - A register draining in the same cycle as a new pulse for the same source accepts the new pulse, with no overflow.
- Per-core fetch FSM, states IDLE, WAIT, HOLD, DELIVER:
  - IDLE, on `rd_req_c`: latch `rd_addr_c`, load counter with RD_LAT-1, go to WAIT.
  - WAIT: decrement counter. At 0, go to HOLD if any holding register is valid, otherwise to DELIVER.
  - HOLD: stay while any holding register is valid, then go to DELIVER. Fetches never return stale data relative to queued write-backs.
  - DELIVER: read array at the latched address, pulse `mem_data_valid_c`, return to IDLE.
  - `abort_c` in WAIT or HOLD returns the FSM to IDLE with no delivery. `abort_c` in IDLE or DELIVER is ignored.
  - `rd_req_c` while not IDLE is ignored; the cache holds at most one outstanding miss.
- Array has one write port (drain) and two read ports (one per core). A DELIVER read in the same cycle as a drain write to the same address returns the new data (write-first).
- `rd_busy_c` = FSM not IDLE.

## Timing
- Reset values: `mem_data_delivery_c` = 0, `mem_data_valid_c` = 0, `rd_busy_c` = 0, `wb_overflow` = 0. Holding registers invalid, FSMs IDLE. Array contents are not reset.
- Reset mid-fetch: FSM returns to IDLE immediately; no strobe after reset deasserts.
- Fetch latency with empty holding registers: `rd_req_c` at cycle t gives `mem_data_valid_c` at cycle t+RD_LAT.
- Write-back at cycle t is in the array from cycle t+1 if it wins arbitration, otherwise after lower-index sources drain. Four simultaneous pulses drain by cycle t+4.
- `mem_data_delivery_c` holds its value until the next delivery.

## Structure
- The shared cache package holds:
  - the bus request encoding (`BUS_INVALIDATE`=2'b00, `BUS_WRITE_MISS`=2'b01, `BUS_READ_MISS`=2'b10);
  - `ADDR_W` and `DATA_W` constants;
  - the fetch FSM state enum.
- One sub-module, `mem_fetch_fsm`, instantiated twice (one per core). Holding registers, arbiter and array stay in the top.

## Test plan
- Fetch: preload addr 9'h014 = 32'hDEADBEEF; `rd_req_0` at t → `mem_data_valid_0` at t+2 with 32'hDEADBEEF, `rd_busy_0` high t+1..t+2.
- Write then read: `cpu_wb_1` to 9'h0A0 = 32'h12345678 at t, `rd_req_0` 9'h0A0 at t → delivery 32'h12345678 at t+2.
- Simultaneous write-backs: all four sources pulse at t with distinct addresses → all four in the array by t+4, `wb_overflow` = 0. Then `bus_wb_1` twice in consecutive cycles while blocked behind `bus_wb_0` and `cpu_wb_0` traffic → `wb_overflow` = 1.
- Abort: `rd_req_1` at t, `abort_1` at t+1 → no `mem_data_valid_1`, `rd_busy_1` = 0 at t+2. A new request at t+3 delivers at t+5.
- HOLD path: keep the arbiter busy with core-0 write-backs so `cpu_wb_1` (addr 9'h033 = 32'hCAFEF00D) stays queued; `rd_req_1` on 9'h033 → delivery delayed until the queue empties, value 32'hCAFEF00D.
- Reset mid-fetch: `reset` pulse at t+1 after `rd_req_0` at t → no strobe; all outputs 0; `wb_overflow` cleared.
